// File: rtl/rocketcpu_wb_arbiter3.sv
// rtl/rocketcpu_wb_arbiter3.sv - three-master round-robin Wishbone arbiter, grant held per transaction
// Optional transaction watchdog enabled by defining ROCKETCPU_ARB_TIMEOUT_EN.
module rocketcpu_wb_arbiter3 #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        i_wb_clk,
    input  logic        reset,
    input  logic [31:0] i_m0_adr,
    input  logic        i_m0_cyc,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    input  logic [31:0] i_m2_adr,
    input  logic [31:0] i_m2_dat,
    input  logic [3:0]  i_m2_sel,
    input  logic        i_m2_we,
    input  logic        i_m2_cyc,
    output logic [31:0] o_m2_rdt,
    output logic        o_m2_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic [1:0]  o_grant,
    output logic        o_err
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam logic [1:0] NONE = 2'd3;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("TIMEOUT must be at least 2");
    end

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  last_q;
    logic [1:0]  pick_d;
    logic [2:0]  req;
    logic [2:0]  slot;
    logic        busy;
    logic        done;
    logic        ack_any;
    logic        tmo_fire;
    logic        g_cyc;
    logic        g_we;
    logic [31:0] g_adr;
    logic [31:0] g_dat;
    logic [3:0]  g_sel;
    logic [31:0] rdt_sel;

    assign req  = {i_m2_cyc, i_m1_cyc, i_m0_cyc};
    assign busy = (state_q == BUSY);

    // Walk the candidates from farthest to nearest so the nearest to last+1 wins.
    always_comb begin
        pick_d = NONE;
        slot   = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            slot = {1'b0, last_q} + 3'(k) + 3'd1;
            if (slot >= 3'd3) slot = slot - 3'd3;
            if (req[slot[1:0]]) pick_d = slot[1:0];
        end
    end

    // grant_q is NONE whenever IDLE, so the default arm zeroes the slave side.
    always_comb begin
        g_cyc = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        case (grant_q)
            2'd0: begin g_cyc = i_m0_cyc; g_adr = i_m0_adr; g_sel = 4'hF; end
            2'd1: begin g_cyc = i_m1_cyc; g_adr = i_m1_adr; g_dat = i_m1_dat; g_sel = i_m1_sel; g_we = i_m1_we; end
            2'd2: begin g_cyc = i_m2_cyc; g_adr = i_m2_adr; g_dat = i_m2_dat; g_sel = i_m2_sel; g_we = i_m2_we; end
            default: ;
        endcase
    end

`ifdef ROCKETCPU_ARB_TIMEOUT_EN
    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_wb_clk) begin
        if (reset || !busy) begin
            cnt_q <= '0;
        end else if (!i_wb_ack && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tmo_fire = busy && g_cyc && !i_wb_ack && (cnt_q == CNT_LAST);
`else
    assign tmo_fire = 1'b0;
`endif

    assign done    = busy && (i_wb_ack || !g_cyc || tmo_fire);
    assign ack_any = busy && (i_wb_ack || tmo_fire);
    assign rdt_sel = tmo_fire ? ERR_DATA : i_wb_rdt;

    assign o_wb_cyc = busy && g_cyc && !tmo_fire;
    assign o_wb_adr = g_adr;
    assign o_wb_dat = g_dat;
    assign o_wb_sel = g_sel;
    assign o_wb_we  = g_we;
    assign o_grant  = grant_q;
    assign o_err    = tmo_fire;

    assign o_m0_ack = ack_any && (grant_q == 2'd0);
    assign o_m1_ack = ack_any && (grant_q == 2'd1);
    assign o_m2_ack = ack_any && (grant_q == 2'd2);
    assign o_m0_rdt = (busy && grant_q == 2'd0) ? rdt_sel : '0;
    assign o_m1_rdt = (busy && grant_q == 2'd1) ? rdt_sel : '0;
    assign o_m2_rdt = (busy && grant_q == 2'd2) ? rdt_sel : '0;

    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= NONE;
            last_q  <= 2'd2;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 3'b000) begin
                        state_q <= BUSY;
                        grant_q <= pick_d;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state_q <= IDLE;
                        grant_q <= NONE;
                        last_q  <= grant_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rocketcpu_wb_arbiter3.sv
// tb/tb_rocketcpu_wb_arbiter3.sv - scoreboard bench for the three-master Wishbone arbiter
// Timeout checks follow ROCKETCPU_ARB_TIMEOUT_EN.
module tb_rocketcpu_wb_arbiter3;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    typedef struct { int cyc; int g; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic we; } grant_t;
    typedef struct { int cyc; int g; logic [31:0] rdt; logic err; } ack_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] m_adr [3];
    logic [31:0] m_dat [3];
    logic [3:0]  m_sel [3];
    logic        m_we  [3];
    logic        m_cyc [3];
    logic [31:0] s_rdt [3];
    logic        s_ack [3];
    logic [31:0] wb_adr, wb_dat;
    logic [31:0] wb_rdt = '0;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc;
    logic        wb_ack = 1'b0;
    logic [1:0]  grant;
    logic        err;

    rocketcpu_wb_arbiter3 #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .i_wb_clk(clk), .reset(reset),
        .i_m0_adr(m_adr[0]), .i_m0_cyc(m_cyc[0]), .o_m0_rdt(s_rdt[0]), .o_m0_ack(s_ack[0]),
        .i_m1_adr(m_adr[1]), .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]), .i_m1_we(m_we[1]),
        .i_m1_cyc(m_cyc[1]), .o_m1_rdt(s_rdt[1]), .o_m1_ack(s_ack[1]),
        .i_m2_adr(m_adr[2]), .i_m2_dat(m_dat[2]), .i_m2_sel(m_sel[2]), .i_m2_we(m_we[2]),
        .i_m2_cyc(m_cyc[2]), .o_m2_rdt(s_rdt[2]), .o_m2_ack(s_ack[2]),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
        .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_grant(grant), .o_err(err)
    );

    int     checks = 0, errors = 0, cyc_n = 0;
    grant_t exp_g [$];
    ack_t   exp_a [$];

    // Transaction-level reference: who owns the bus, who went last, slave delay left.
    bit m_busy = 1'b0;
    int m_owner = 0, m_last = 2, m_wait = 0, m_tcnt = 0, tx_done = 0;
    int ack_dly = 0;
    bit auto_req = 1'b0, stray_ok = 1'b0, drop_on_ack = 1'b1;
    bit raise_req [3];
    bit drop_pend [3];
    int cool [3];
    bit          d_use [3];
    logic [31:0] d_adr [3];
    logic [31:0] d_dat [3];
    logic [3:0]  d_sel [3];
    logic        d_we  [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic raise(input int m);
        m_cyc[m] = 1'b1;
        m_adr[m] = d_use[m] ? d_adr[m] : $urandom;
        m_dat[m] = d_use[m] ? d_dat[m] : $urandom;
        m_sel[m] = d_use[m] ? d_sel[m] : 4'($urandom_range(0, 15));
        m_we[m]  = d_use[m] ? d_we[m]  : 1'($urandom_range(0, 1));
    endtask

    task automatic step(input bit do_rst);
        bit ack, tfire;
        int pick, c;
        logic [31:0] rdt;
        @(negedge clk);
        cyc_n++;
        reset = do_rst;
        for (int m = 0; m < 3; m++) begin
            if (drop_pend[m]) begin
                m_cyc[m] = 1'b0; drop_pend[m] = 1'b0; cool[m] = $urandom_range(0, 3);
            end else if (raise_req[m]) begin
                raise(m); raise_req[m] = 1'b0;
            end else if (auto_req && !m_cyc[m]) begin
                if (cool[m] > 0) cool[m]--;
                else if ($urandom_range(0, 99) < 40) raise(m);
            end
        end
        ack = 1'b0; tfire = 1'b0; rdt = $urandom;
        if (m_busy && !do_rst && m_cyc[m_owner]) begin
            if (m_wait == 0) ack = 1'b1; else m_wait--;
`ifdef ROCKETCPU_ARB_TIMEOUT_EN
            if (!ack && m_tcnt == TMO - 1) tfire = 1'b1;
`endif
            if (ack || tfire) exp_a.push_back(ack_t'{cyc_n, m_owner, tfire ? ERRD : rdt, tfire});
        end else if (!m_busy && stray_ok && $urandom_range(0, 9) == 0) begin
            ack = 1'b1;
        end
        wb_rdt = rdt;
        wb_ack = ack;
        if (do_rst) begin
            m_busy = 1'b0; m_last = 2;
        end else if (m_busy) begin
            if (ack || tfire || !m_cyc[m_owner]) begin
                m_busy = 1'b0; m_last = m_owner;
                if (ack || tfire) begin
                    tx_done++;
                    if (drop_on_ack) drop_pend[m_owner] = 1'b1;
                end
            end else begin
                m_tcnt++;
            end
        end else begin
            pick = -1;
            for (int k = 1; k <= 3; k++) begin
                c = (m_last + k) % 3;
                if (pick < 0 && m_cyc[c]) pick = c;
            end
            if (pick >= 0) begin
                m_busy = 1'b1; m_owner = pick; m_tcnt = 0;
                m_wait = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
                exp_g.push_back(grant_t'{cyc_n + 1, pick, m_adr[pick],
                    pick == 0 ? 32'h0 : m_dat[pick], pick == 0 ? 4'hF : m_sel[pick],
                    pick == 0 ? 1'b0 : m_we[pick]});
            end
        end
    endtask

    task automatic run_until(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (tx_done < target && n < limit) begin step(1'b0); n++; end
        chk(name, 32'(tx_done >= target), 32'd1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT acks a master or raises o_wb_cyc.
    initial begin
        ack_t   ea;
        grant_t cur;
        bit     cur_v, prev, bad;
        int     n, g;
        cur_v = 1'b0; prev = 1'b0;
        forever begin
            @(negedge clk); #3;
            n = 0; g = 0;
            for (int m = 0; m < 3; m++) if (s_ack[m]) begin n++; g = m; end
            if (n > 1) begin
                checks++; errors++; $display("FAIL multi_ack: %0d acks at cycle %0d, at most 1 allowed", n, cyc_n);
            end else if (n == 1) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++; $display("FAIL unexpected_ack: master %0d at cycle %0d, none expected", g, cyc_n);
                end else begin
                    ea = exp_a.pop_front();
                    chk("ack_cycle", cyc_n, ea.cyc);
                    chk("ack_master", g, ea.g);
                    chk("ack_rdt", s_rdt[g], ea.rdt);
                    chk("ack_err", 32'(err), 32'(ea.err));
                end
            end else if (err) begin
                checks++; errors++; $display("FAIL err_without_ack: o_err=1 at cycle %0d, expected 0", cyc_n);
            end
            while (exp_a.size() > 0 && exp_a[0].cyc < cyc_n) begin
                ea = exp_a.pop_front();
                checks++; errors++; $display("FAIL missed_ack: master %0d due cycle %0d, got none", ea.g, ea.cyc);
            end
            if (wb_cyc && !prev) begin
                if (exp_g.size() == 0) begin
                    checks++; errors++; $display("FAIL unexpected_cyc: o_wb_cyc rose at cycle %0d, none expected", cyc_n);
                end else begin
                    cur = exp_g.pop_front(); cur_v = 1'b1;
                    chk("grant_cycle", cyc_n, cur.cyc);
                    chk("grant_master", 32'(grant), cur.g);
                end
            end
            while (exp_g.size() > 0 && exp_g[0].cyc < cyc_n) begin
                cur = exp_g.pop_front(); cur_v = 1'b0;
                checks++; errors++; $display("FAIL missed_grant: master %0d due cycle %0d, got none", cur.g, cur.cyc);
            end
            if (wb_cyc && cur_v) begin
                bad = (grant != 2'(cur.g)) || (wb_adr != cur.adr) || (wb_dat != cur.dat) ||
                      (wb_sel != cur.sel) || (wb_we != cur.we);
                for (int m = 0; m < 3; m++) if (m != cur.g && s_rdt[m] != 32'h0) bad = 1'b1;
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL slave_side: g=%0d adr=%0h dat=%0h sel=%0h we=%0d expected g=%0d adr=%0h dat=%0h sel=%0h we=%0d, idle rdt 0",
                             grant, wb_adr, wb_dat, wb_sel, wb_we, cur.g, cur.adr, cur.dat, cur.sel, cur.we);
                end
            end
            prev = wb_cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bad, n;
        for (int m = 0; m < 3; m++) begin
            m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0; m_cyc[m] = 1'b0;
            d_use[m] = 1'b0; d_adr[m] = '0; d_dat[m] = '0; d_sel[m] = '0; d_we[m] = 1'b0;
        end
        step(1'b1); step(1'b1); step(1'b0); #3;
        chk("rst_grant", 32'(grant), 32'd3);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_acks", 32'({s_ack[0], s_ack[1], s_ack[2]}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_adr", wb_adr, 32'd0);

        // Single ibus read, slave acks two cycles after o_wb_cyc.
        d_use[0] = 1'b1; d_adr[0] = 32'h0010_0000; ack_dly = 2; drop_on_ack = 1'b1;
        raise_req[0] = 1'b1;
        run_until(tx_done + 1, 20, "t1_done");
        d_use[0] = 1'b0;
        step(1'b0);

        // All three requesting continuously: strict 0,1,2 rotation.
        ack_dly = 1; drop_on_ack = 1'b0;
        for (int m = 0; m < 3; m++) raise_req[m] = 1'b1;
        run_until(tx_done + 6, 40, "t2_done");
        for (int m = 0; m < 3; m++) drop_pend[m] = 1'b1;
        step(1'b0); step(1'b0);

        // dbus write contending with ibus.
        d_use[1] = 1'b1; d_adr[1] = 32'h0200_0000; d_dat[1] = 32'h1; d_sel[1] = 4'hF; d_we[1] = 1'b1;
        ack_dly = -1; drop_on_ack = 1'b1;
        raise_req[0] = 1'b1; raise_req[1] = 1'b1;
        run_until(tx_done + 2, 30, "t3_done");
        d_use[1] = 1'b0;
        step(1'b0); step(1'b0);

        // dbus aborts mid-transaction; pointer advances past it.
        ack_dly = 1000; raise_req[1] = 1'b1;
        step(1'b0); step(1'b0); step(1'b0);
        drop_pend[1] = 1'b1; step(1'b0);
        ack_dly = 0; raise_req[0] = 1'b1; raise_req[2] = 1'b1;
        run_until(tx_done + 2, 20, "abort_then_rr");
        step(1'b0); step(1'b0);

        // Reset during the second BUSY cycle of a master-2 transfer.
        ack_dly = 1000; raise_req[2] = 1'b1;
        step(1'b0); step(1'b0); step(1'b1);
        ack_dly = 0; raise_req[0] = 1'b1;
        step(1'b0); #3;
        chk("midrst_grant", 32'(grant), 32'd3);
        chk("midrst_cyc", 32'(wb_cyc), 32'd0);
        run_until(tx_done + 2, 20, "midrst_after");
        step(1'b0); step(1'b0);

        // Random traffic with stray slave acks while idle.
        auto_req = 1'b1; stray_ok = 1'b1; ack_dly = -1;
        repeat (400) step(1'b0);
        auto_req = 1'b0; stray_ok = 1'b0;
        n = 0;
        while ((m_busy || m_cyc[0] || m_cyc[1] || m_cyc[2]) && n < 100) begin step(1'b0); n++; end
        chk("drain", 32'(m_busy || m_cyc[0] || m_cyc[1] || m_cyc[2]), 32'd0);
        step(1'b0);

        // dbus read to a slave that never acks.
        d_use[1] = 1'b1; d_adr[1] = 32'h3000_0000; d_we[1] = 1'b0; d_sel[1] = 4'hF; d_dat[1] = 32'h0;
        ack_dly = 1000000; raise_req[1] = 1'b1;
`ifdef ROCKETCPU_ARB_TIMEOUT_EN
        run_until(tx_done + 1, 30, "tmo_done");
        step(1'b0); #3;
        chk("tmo_idle_cyc", 32'(wb_cyc), 32'd0);
        chk("tmo_idle_grant", 32'(grant), 32'd3);
`else
        step(1'b0);
        bad = 0;
        base = cyc_n;
        repeat (2000) begin
            step(1'b0); #3;
            if (!wb_cyc || err) bad++;
        end
        chk("stall_bad_cycles", bad, 32'd0);
        chk("stall_len", cyc_n - base, 32'd2000);
        drop_pend[1] = 1'b1;
        step(1'b1); step(1'b0); #3;
        chk("stall_rst_cyc", 32'(wb_cyc), 32'd0);
`endif
        step(1'b0); step(1'b0);
        chk("leftover_acks", exp_a.size(), 32'd0);
        chk("leftover_grants", exp_g.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
